// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Runs radix-2 shift-add multiply or restoring divide on operand magnitudes, then fixes up signs.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done,
  output logic             divz
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  localparam logic [WIDTH-1:0] CntLast = WIDTH'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 bzero_q, bzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divz_q, divz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       add_sum, shifted, diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, mul_res;
  logic [WIDTH-1:0]     quo, rem, quo_res, rem_res;

  // Signed ops (op[0] == 0) work on magnitudes; signs are reapplied in StFix.
  assign a_neg = ~op[0] & srca[WIDTH-1];
  assign b_neg = ~op[0] & srcb[WIDTH-1];
  assign abs_a = a_neg ? -srca : srca;
  assign abs_b = b_neg ? -srcb : srcb;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend/quotient shifting through the low half.
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, opb_q};
  assign ge       = shifted >= {1'b0, opb_q};
  assign div_next = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

  assign mul_res = neg_q ? -acc_q : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[2*WIDTH-1:WIDTH];
  assign quo_res = bzero_q ? '1 : (neg_q ? -quo : quo);
  assign rem_res = neg_rem_q ? -rem : rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divz_d    = divz_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d   = StRun;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          opb_d     = op[1] ? abs_b : abs_a;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (srcb == '0);
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d   = rem_res;
          lo_d   = quo_res;
          divz_d = bzero_q;
        end else begin
          hi_d   = mul_res[2*WIDTH-1:WIDTH];
          lo_d   = mul_res[WIDTH-1:0];
          divz_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort drops the operation without touching architectural state.
    if (flush && state_q != StIdle) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      divz_d  = divz_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign divz  = divz_q;
  assign stall = (state_q != StIdle) || (start && !flush);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed corner cases plus random ops
// compared against a plain-arithmetic reference of the HI/LO results.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb, wdata;
  logic         hi_we, lo_we, flush;
  logic [W-1:0] hi, lo;
  logic         stall, done, divz;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;
  logic         mdl_divz = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .stall (stall),
    .done  (done),
    .divz  (divz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision arithmetic; SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l,
                                output logic dz);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; h = u[63:32]; l = u[31:0]; end
      default: begin
        if (b == '0) begin
          dz = 1'b1;
          h  = a;
          l  = '1;
        end else if (o == 2'b10) begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // mode: 0 plain, 1 re-pulse start mid-RUN, 2 hi_we mid-RUN, 3 hi_we together with start
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode);
    logic [W-1:0] eh, el, hold_hi;
    logic         ed;
    int           cycles, early;
    model(o, a, b, eh, el, ed);
    op = o; srca = a; srcb = b; start = 1'b1;
    if (mode == 3) begin hi_we = 1'b1; wdata = 32'h0BAD_F00D; end
    #1 check("stall_on_start", stall, 1);
    tick();
    start = 1'b0; hi_we = 1'b0;
    if (mode == 3) check("hi_we_with_start", hi, 32'h0BAD_F00D);
    hold_hi = hi;
    cycles = 1;
    early  = 0;
    while (stall && cycles < 200) begin
      if (done) early++;
      if (cycles == 5 && mode == 1) begin start = 1'b1; op = 2'b11; srca = 32'h1234; srcb = 7; end
      if (cycles == 5 && mode == 2) begin hi_we = 1'b1; wdata = 32'h1234_5678; end
      tick();
      start = 1'b0; hi_we = 1'b0;
      cycles++;
      if (cycles == 6 && mode == 2) check("hi_we_ignored_run", hi, hold_hi);
    end
    check("stall_cycles", cycles, W + 2);
    check("early_done", early, 0);
    check("done_pulse", done, 1);
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    check("divz_result", divz, ed);
    mdl_hi = eh; mdl_lo = el; mdl_divz = ed;
    tick();
    check("done_single", done, 0);
    check("idle_after", stall, 0);
  endtask

  initial begin
    int dcount;
    logic [W-1:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;

    // Reset state
    #2;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_done", done, 0);
    check("rst_divz", divz, 0);
    check("rst_stall_lo", stall, 0);
    start = 1'b1;
    #1 check("rst_stall_eq_start", stall, 1);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Directed results
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 0);
    run_op(2'b01, 32'h0000_0003, 32'h0000_0003, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    check("repulse_no_restart", stall, 0);
    run_op(2'b10, 32'hFFFF_FF00, 32'h0000_0000, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 2);
    run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 3);

    // Direct HI/LO writes in IDLE
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick();
    hi_we = 1'b0;
    check("idle_hi_we", hi, 32'h1234_5678);
    check("idle_hi_we_lo_kept", lo, mdl_lo);
    lo_we = 1'b1; wdata = 32'hCAFE_0001;
    tick();
    lo_we = 1'b0;
    check("idle_lo_we", lo, 32'hCAFE_0001);
    mdl_hi = 32'h1234_5678; mdl_lo = 32'hCAFE_0001;

    // Flush during RUN
    op = 2'b00; srca = 32'h0000_1111; srcb = 32'h0000_2222; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", stall, 0);
    check("flush_hi", hi, mdl_hi);
    check("flush_lo", lo, mdl_lo);
    check("flush_divz", divz, mdl_divz);
    dcount = 0;
    repeat (40) begin tick(); if (done) dcount++; end
    check("flush_no_done", dcount, 0);
    check("flush_hi_late", hi, mdl_hi);

    // Flush with start in IDLE does not start
    start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", stall, 0);
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_ignored", stall, 0);

    // Reset mid-RUN
    run_op(2'b11, 32'h0000_0009, 32'h0000_0000, 0);
    op = 2'b01; srca = 32'hDEAD_BEEF; srcb = 32'h0000_0013; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_divz", divz, 0);
    check("midrst_stall", stall, 0);
    #2 reset = 1'b1;
    mdl_hi = '0; mdl_lo = '0; mdl_divz = 1'b0;
    dcount = 0;
    repeat (40) begin tick(); if (done) dcount++; end
    check("midrst_no_done", dcount, 0);
    check("midrst_idle", stall, 0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
